// File: rtl/mem_access.sv
// MEM-stage data-memory access unit: aligns and extends loads, steers store lanes,
// stalls the pipeline while a bus access is outstanding and reports address/bus errors.
module mem_access (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemValid,
    input  logic        ClearSigIn,
    input  logic        MemRd,
    input  logic        DMWr,
    input  logic [5:0]  OpIn,
    input  logic [31:0] AddrIn,
    input  logic [31:0] WDIn,
    output logic        DMReq,
    output logic        DMWe,
    output logic [31:0] DMAddr,
    output logic [3:0]  DMBe,
    output logic [31:0] DMWData,
    input  logic [31:0] DMRData,
    input  logic        DMAck,
    output logic [31:0] RDOut,
    output logic        MemStall,
    output logic        AdELOut,
    output logic        AdESOut,
    output logic        BusErrOut,
    output logic [31:0] BadVAddrOut
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t      state;
    logic [3:0]  tmo;
    logic        kill;
    logic        r_byte;
    logic        r_half;
    logic        r_signed;
    logic [1:0]  r_lo;

    logic        is_byte;
    logic        is_half;
    logic        is_signed;
    logic        access;
    logic        aligned;
    logic        start;
    logic        misalign;
    logic        kill_now;
    logic [31:0] lane;
    logic [31:0] load_val;

    // Anything that is not an explicit byte/halfword opcode is a word access.
    always_comb begin
        is_byte   = 1'b0;
        is_half   = 1'b0;
        is_signed = 1'b0;
        case (OpIn)
            6'h20: begin is_byte = 1'b1; is_signed = 1'b1; end
            6'h21: begin is_half = 1'b1; is_signed = 1'b1; end
            6'h24: is_byte = 1'b1;
            6'h25: is_half = 1'b1;
            6'h28: is_byte = 1'b1;
            6'h29: is_half = 1'b1;
            default: ;
        endcase
    end

    assign access   = ~rst & (state == IDLE) & MemValid & (MemRd | DMWr) & ~ClearSigIn;
    assign aligned  = is_byte | (is_half & ~AddrIn[0]) | (AddrIn[1:0] == 2'b00);
    assign start    = access & aligned;
    assign misalign = access & ~aligned;

    assign MemStall    = start | (state == WAIT);
    assign DMReq       = (state == WAIT);
    assign AdELOut     = misalign & MemRd;
    assign AdESOut     = misalign & ~MemRd;
    assign BadVAddrOut = BusErrOut ? {DMAddr[31:2], r_lo} : (misalign ? AddrIn : 32'h0);

    assign kill_now = kill | ClearSigIn;
    assign lane     = DMRData >> {r_lo, 3'b000};

    always_comb begin
        if (r_byte)
            load_val = {{24{r_signed & lane[7]}}, lane[7:0]};
        else if (r_half)
            load_val = {{16{r_signed & lane[15]}}, lane[15:0]};
        else
            load_val = DMRData;
    end

    // A flush in WAIT lets the bus transaction finish but discards its result and any error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            tmo       <= 4'd0;
            kill      <= 1'b0;
            DMWe      <= 1'b0;
            DMAddr    <= 32'h0;
            DMBe      <= 4'h0;
            DMWData   <= 32'h0;
            RDOut     <= 32'h0;
            BusErrOut <= 1'b0;
            r_byte    <= 1'b0;
            r_half    <= 1'b0;
            r_signed  <= 1'b0;
            r_lo      <= 2'b00;
        end else begin
            BusErrOut <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= WAIT;
                        tmo      <= 4'd0;
                        kill     <= 1'b0;
                        DMAddr   <= {AddrIn[31:2], 2'b00};
                        DMWe     <= DMWr;
                        r_byte   <= is_byte;
                        r_half   <= is_half;
                        r_signed <= is_signed;
                        r_lo     <= AddrIn[1:0];
                        if (!DMWr) begin
                            DMBe    <= 4'b1111;
                            DMWData <= 32'h0;
                        end else if (is_byte) begin
                            DMBe    <= 4'b0001 << AddrIn[1:0];
                            DMWData <= {4{WDIn[7:0]}};
                        end else if (is_half) begin
                            DMBe    <= 4'b0011 << AddrIn[1:0];
                            DMWData <= {2{WDIn[15:0]}};
                        end else begin
                            DMBe    <= 4'b1111;
                            DMWData <= WDIn;
                        end
                    end
                end
                WAIT: begin
                    if (ClearSigIn)
                        kill <= 1'b1;
                    if (DMAck) begin
                        state <= DONE;
                        if (!DMWe && !kill_now)
                            RDOut <= load_val;
                    end else if (tmo == 4'd15) begin
                        state <= DONE;
                        if (!kill_now) begin
                            RDOut     <= 32'h0;
                            BusErrOut <= 1'b1;
                        end
                    end else begin
                        tmo <= tmo + 4'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    kill  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed scenarios plus randomized accesses
// compared against a byte-level memory and load-extension reference model.
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemValid;
    logic        ClearSigIn;
    logic        MemRd;
    logic        DMWr;
    logic [5:0]  OpIn;
    logic [31:0] AddrIn;
    logic [31:0] WDIn;
    logic        DMReq;
    logic        DMWe;
    logic [31:0] DMAddr;
    logic [3:0]  DMBe;
    logic [31:0] DMWData;
    logic [31:0] DMRData;
    logic        DMAck;
    logic [31:0] RDOut;
    logic        MemStall;
    logic        AdELOut;
    logic        AdESOut;
    logic        BusErrOut;
    logic [31:0] BadVAddrOut;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_rd;
    logic [7:0]  mem [4];
    logic [7:0]  exp_mem [4];
    logic [5:0]  ops [8] = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B};

    mem_access dut (
        .clk(clk), .rst(rst), .MemValid(MemValid), .ClearSigIn(ClearSigIn),
        .MemRd(MemRd), .DMWr(DMWr), .OpIn(OpIn), .AddrIn(AddrIn), .WDIn(WDIn),
        .DMReq(DMReq), .DMWe(DMWe), .DMAddr(DMAddr), .DMBe(DMBe), .DMWData(DMWData),
        .DMRData(DMRData), .DMAck(DMAck), .RDOut(RDOut), .MemStall(MemStall),
        .AdELOut(AdELOut), .AdESOut(AdESOut), .BusErrOut(BusErrOut),
        .BadVAddrOut(BadVAddrOut)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        MemValid   = 1'b0;
        ClearSigIn = 1'b0;
        MemRd      = 1'b0;
        DMWr       = 1'b0;
        OpIn       = 6'h0;
        AddrIn     = 32'h0;
        WDIn       = 32'h0;
        DMAck      = 1'b0;
    endtask

    function automatic int size_of(input logic [5:0] op);
        if (op == 6'h20 || op == 6'h24 || op == 6'h28) return 1;
        if (op == 6'h21 || op == 6'h25 || op == 6'h29) return 2;
        return 4;
    endfunction

    function automatic bit is_store(input logic [5:0] op);
        return (op == 6'h28 || op == 6'h29 || op == 6'h2B);
    endfunction

    // Load result from the addressed bytes, with arithmetic sign handling.
    function automatic logic [31:0] ref_load(input logic [5:0] op, input logic [31:0] addr,
                                             input logic [31:0] data);
        logic [31:0] v;
        int          sz;
        sz = size_of(op);
        if (sz == 4) return data;
        v = (data >> (8 * (addr % 4))) % (sz == 1 ? 256 : 65536);
        if (op == 6'h20 && v >= 128) v = v + 32'hFFFF_FF00;
        if (op == 6'h21 && v >= 32768) v = v + 32'hFFFF_0000;
        return v;
    endfunction

    // One access starting in IDLE; ends back in IDLE. clear_at<0 means no flush.
    task automatic do_access(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wd,
                             input logic [31:0] rdata, input int delay, input int clear_at);
        bit load;
        bit killed;
        int sz;
        load   = !is_store(op);
        sz     = size_of(op);
        killed = (clear_at >= 0) && (clear_at < delay);
        MemValid = 1'b1; MemRd = load; DMWr = !load; OpIn = op; AddrIn = addr; WDIn = wd;
        ClearSigIn = 1'b0; DMAck = 1'b0;
        #1;
        if (addr % sz != 0) begin
            check("misalign_stall", MemStall, 0);
            check("misalign_adel", AdELOut, load);
            check("misalign_ades", AdESOut, !load);
            check("misalign_badv", BadVAddrOut, addr);
            tick();
            idle_inputs();
            #1;
            check("misalign_noreq", DMReq, 0);
            check("misalign_adel_gone", AdELOut, 0);
            return;
        end
        check("start_stall", MemStall, 1);
        check("start_no_adel", AdELOut | AdESOut, 0);
        tick();
        idle_inputs();
        #1;
        check("wait_req", DMReq, 1);
        check("wait_addr", DMAddr, addr - (addr % 4));
        check("wait_we", DMWe, !load);
        if (load) begin
            check("load_be", DMBe, 4'hF);
            check("load_wdata", DMWData, 0);
        end else begin
            for (int k = 0; k < 4; k++) begin
                mem[k] = 8'($urandom);
                exp_mem[k] = mem[k];
            end
            for (int k = 0; k < 4; k++)
                if (DMBe[k]) mem[k] = DMWData[8*k +: 8];
            for (int j = 0; j < sz; j++)
                exp_mem[(addr % 4) + j] = wd[8*j +: 8];
            for (int k = 0; k < 4; k++)
                check("store_byte", mem[k], exp_mem[k]);
        end
        for (int i = 0; i < delay; i++) begin
            ClearSigIn = (i == clear_at);
            tick();
            ClearSigIn = 1'b0;
            #1;
            check("wait_hold_req", DMReq, 1);
        end
        DMAck = 1'b1; DMRData = rdata;
        #1;
        check("ack_stall", MemStall, 1);
        tick();
        DMAck = 1'b0; DMRData = $urandom;
        #1;
        if (load && !killed) exp_rd = ref_load(op, addr, rdata);
        check("done_stall", MemStall, 0);
        check("done_req", DMReq, 0);
        check("done_buserr", BusErrOut, 0);
        check("done_rdout", RDOut, exp_rd);
        tick();
        check("idle_req", DMReq, 0);
        check("idle_rdout", RDOut, exp_rd);
    endtask

    initial begin
        int cnt;
        logic [5:0]  op;
        logic [31:0] addr;
        int          dly;
        int          clr;

        idle_inputs();
        DMRData = 32'h0;
        rst = 1'b1;
        exp_rd = 32'h0;
        tick();
        tick();
        check("reset_req", DMReq, 0);
        check("reset_stall", MemStall, 0);
        check("reset_addr", DMAddr, 0);
        check("reset_be", {28'h0, DMBe}, 0);
        check("reset_rdout", RDOut, 0);
        check("reset_badv", BadVAddrOut, 0);
        rst = 1'b0;
        tick();

        // lb, sign-extended top lane, ack on first WAIT cycle
        do_access(6'h20, 32'h1003, 32'h0, 32'h80FF_1234, 0, -1);
        check("s1_rdout", RDOut, 32'hFFFF_FF80);

        // sh to upper half: lanes and replicated data, RDOut untouched
        do_access(6'h29, 32'h2002, 32'hDEAD_BEEF, 32'h0, 1, -1);
        check("s2_addr", DMAddr, 32'h2000);
        check("s2_be", {28'h0, DMBe}, 32'hC);
        check("s2_wdata", DMWData, 32'hBEEF_BEEF);
        check("s2_we", DMWe, 1);
        check("s2_rdout", RDOut, 32'hFFFF_FF80);

        // misaligned lw
        do_access(6'h23, 32'h1001, 32'h0, 32'h0, 0, -1);

        // lhu with no ack -> timeout after 16 request cycles
        MemValid = 1'b1; MemRd = 1'b1; OpIn = 6'h25; AddrIn = 32'h4000;
        #1;
        check("s4_start_stall", MemStall, 1);
        tick();
        idle_inputs();
        #1;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (DMReq !== 1'b1) break;
            cnt++;
            tick();
        end
        check("s4_req_cycles", cnt, 16);
        check("s4_buserr", BusErrOut, 1);
        check("s4_badv", BadVAddrOut, 32'h4000);
        check("s4_rdout", RDOut, 0);
        check("s4_stall", MemStall, 0);
        exp_rd = 32'h0;
        tick();
        check("s4_buserr_pulse", BusErrOut, 0);
        check("s4_badv_clear", BadVAddrOut, 0);

        // set a known value, then a flushed lw must not overwrite it
        do_access(6'h23, 32'h0000_1230, 32'h0, 32'hCAFE_0001, 2, -1);
        do_access(6'h23, 32'h0000_1240, 32'h0, 32'h1234_5678, 3, 0);
        check("s5_rdout_kept", RDOut, 32'hCAFE_0001);

        // flush in IDLE suppresses both start and address error
        MemValid = 1'b1; MemRd = 1'b1; OpIn = 6'h23; AddrIn = 32'h1002; ClearSigIn = 1'b1;
        #1;
        check("flush_idle_adel", AdELOut, 0);
        check("flush_idle_badv", BadVAddrOut, 0);
        AddrIn = 32'h1000;
        #1;
        check("flush_idle_stall", MemStall, 0);
        tick();
        idle_inputs();
        #1;
        check("flush_idle_req", DMReq, 0);

        // stray ack while idle
        DMAck = 1'b1; DMRData = 32'h5555_AAAA;
        tick();
        DMAck = 1'b0;
        #1;
        check("stray_ack_rdout", RDOut, exp_rd);
        check("stray_ack_req", DMReq, 0);

        // reset in WAIT abandons the access
        MemValid = 1'b1; MemRd = 1'b1; OpIn = 6'h23; AddrIn = 32'h0100;
        #1;
        tick();
        idle_inputs();
        #1;
        check("s6_req_before", DMReq, 1);
        #2;
        rst = 1'b1;
        #1;
        check("s6_req_async", DMReq, 0);
        check("s6_stall_async", MemStall, 0);
        tick();
        rst = 1'b0;
        exp_rd = 32'h0;
        DMAck = 1'b1; DMRData = 32'h1111_2222;
        tick();
        DMAck = 1'b0;
        #1;
        check("s6_req_after", DMReq, 0);
        check("s6_rdout", RDOut, 0);
        check("s6_buserr", BusErrOut, 0);
        check("s6_stall", MemStall, 0);

        // randomized accesses
        for (int n = 0; n < 60; n++) begin
            op   = ops[$urandom_range(0, 7)];
            addr = $urandom;
            dly  = $urandom_range(0, 4);
            clr  = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 3) : -1;
            do_access(op, addr, $urandom, $urandom, dly, clr);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
